// File: rtl/sum_entry_ctrl_if.sv
// sum_entry_ctrl_if: keypad, adder and display signals of the entry sequencer.
//   key_code/key_valid : keypad scanner key strobe
//   op_a/op_b          : BCD operands presented to the adder
//   add_start/add_done : adder start pulse and result-valid strobe
//   sum_in             : adder result
//   disp_value         : value for the 7-segment driver
//   busy/err           : CALC and ERR status
// Modport slave is the sequencer; master is the keypad/adder/display side.
interface sum_entry_ctrl_if #(
    parameter int unsigned W = 12
);
    logic [3:0]   key_code;
    logic         key_valid;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         add_start;
    logic         add_done;
    logic [W-1:0] sum_in;
    logic [W-1:0] disp_value;
    logic         busy;
    logic         err;

    modport master (
        output key_code, key_valid, add_done, sum_in,
        input  op_a, op_b, add_start, disp_value, busy, err
    );

    modport slave (
        input  key_code, key_valid, add_done, sum_in,
        output op_a, op_b, add_start, disp_value, busy, err
    );
endinterface

// File: rtl/sum_entry_ctrl.sv
// sum_entry_ctrl: keypad-entry sequencer for the BCD operand adder.
// Collects operand A and B digit by digit, pulses add_start, waits (bounded
// by TIMEOUT) for add_done, shows the sum, and selects the display value.
//   clk     : system clock, rising edge
//   rst_n   : asynchronous active-low reset
//   ctrl_if : keypad strobes, adder handshake, operands, display and status
module sum_entry_ctrl #(
    parameter int unsigned DIGITS  = 3,
    parameter int unsigned TIMEOUT = 255
) (
    input logic            clk,
    input logic            rst_n,
    sum_entry_ctrl_if.slave ctrl_if
);
    localparam int unsigned W    = 4 * DIGITS;
    localparam int unsigned CntW = $clog2(DIGITS + 1);
    localparam int unsigned TmoW = $clog2(TIMEOUT + 1);

    localparam logic [3:0] KeyPlus  = 4'hA;
    localparam logic [3:0] KeyEqual = 4'hB;
    localparam logic [3:0] KeyClear = 4'hC;

    typedef enum logic [2:0] {StEnterA, StEnterB, StCalc, StShow, StErr} state_e;

    state_e            state_q, state_d;
    logic [W-1:0]      op_a_q, op_a_d;
    logic [W-1:0]      op_b_q, op_b_d;
    logic [W-1:0]      res_q, res_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [TmoW-1:0]   tmo_q, tmo_d;
    logic              start_q, start_d;

    logic is_digit, is_plus, is_equal, is_clear, room;

    always_comb begin
        is_digit = ctrl_if.key_valid && (ctrl_if.key_code <= 4'd9);
        is_plus  = ctrl_if.key_valid && (ctrl_if.key_code == KeyPlus);
        is_equal = ctrl_if.key_valid && (ctrl_if.key_code == KeyEqual);
        is_clear = ctrl_if.key_valid && (ctrl_if.key_code == KeyClear);
        room     = cnt_q < CntW'(DIGITS);
    end

    always_comb begin
        state_d = state_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        start_d = 1'b0;

        // Clear outranks everything, including a same-cycle add_done or timeout.
        if (is_clear) begin
            state_d = StEnterA;
            op_a_d  = '0;
            op_b_d  = '0;
            res_d   = '0;
            cnt_d   = '0;
            tmo_d   = '0;
        end else begin
            unique case (state_q)
                StEnterA: begin
                    if (is_digit && room) begin
                        op_a_d = {op_a_q[W-5:0], ctrl_if.key_code};
                        cnt_d  = cnt_q + CntW'(1);
                    end else if (is_plus) begin
                        state_d = StEnterB;
                        cnt_d   = '0;
                    end
                end
                StEnterB: begin
                    if (is_digit && room) begin
                        op_b_d = {op_b_q[W-5:0], ctrl_if.key_code};
                        cnt_d  = cnt_q + CntW'(1);
                    end else if (is_equal) begin
                        state_d = StCalc;
                        tmo_d   = '0;
                        start_d = 1'b1;
                    end
                end
                StCalc: begin
                    // start_q marks the first CALC cycle, where add_done is not trusted.
                    if (ctrl_if.add_done && !start_q) begin
                        res_d   = ctrl_if.sum_in;
                        state_d = StShow;
                    end else begin
                        tmo_d = tmo_q + TmoW'(1);
                        if (tmo_d == TmoW'(TIMEOUT)) begin
                            state_d = StErr;
                        end
                    end
                end
                StShow: begin
                    if (is_digit) begin
                        op_a_d  = {{(W-4){1'b0}}, ctrl_if.key_code};
                        op_b_d  = '0;
                        cnt_d   = CntW'(1);
                        state_d = StEnterA;
                    end
                end
                StErr: begin
                    // Only clear leaves ERR.
                end
                default: state_d = StEnterA;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StEnterA;
            op_a_q  <= '0;
            op_b_q  <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            tmo_q   <= '0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            start_q <= start_d;
        end
    end

    // Status and display decode only registered state.
    always_comb begin
        ctrl_if.op_a      = op_a_q;
        ctrl_if.op_b      = op_b_q;
        ctrl_if.add_start = start_q;
        ctrl_if.busy      = (state_q == StCalc);
        ctrl_if.err       = (state_q == StErr);
        unique case (state_q)
            StEnterA:        ctrl_if.disp_value = op_a_q;
            StEnterB, StCalc: ctrl_if.disp_value = op_b_q;
            StShow:          ctrl_if.disp_value = res_q;
            StErr:           ctrl_if.disp_value = {DIGITS{4'hF}};
            default:         ctrl_if.disp_value = op_a_q;
        endcase
    end
endmodule

// File: tb/tb_sum_entry_ctrl.sv
// tb_sum_entry_ctrl: self-checking bench for sum_entry_ctrl (TIMEOUT = 4).
// Expected sums are queued when '=' is driven and popped once SHOW is reached.
module tb_sum_entry_ctrl;
    localparam int unsigned DIGITS  = 3;
    localparam int unsigned TIMEOUT = 4;
    localparam int unsigned W       = 4 * DIGITS;

    localparam logic [3:0] KeyPlus  = 4'hA;
    localparam logic [3:0] KeyEqual = 4'hB;
    localparam logic [3:0] KeyClear = 4'hC;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sum_entry_ctrl_if #(.W(W)) bus ();

    sum_entry_ctrl #(
        .DIGITS (DIGITS),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ctrl_if(bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int start_cnt = 0;
    int start_double = 0;
    logic start_prev = 1'b0;
    logic [W-1:0] sb_q[$];

    // add_start pulses seen at clock edges, and any back-to-back pair.
    always @(posedge clk) begin
        if (bus.add_start) start_cnt++;
        if (bus.add_start && start_prev) start_double++;
        start_prev = bus.add_start;
    end

    task automatic check_val(input string tag, input logic [W-1:0] got,
                             input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] bcd_add(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        logic [4:0]   s;
        logic         c;
        r = '0;
        c = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            s = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'b0, c};
            if (s > 5'd9) begin
                s = s + 5'd6;
                c = 1'b1;
            end else begin
                c = 1'b0;
            end
            r[4*i +: 4] = s[3:0];
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] k);
        bus.key_code  = k;
        bus.key_valid = 1'b1;
        tick();
        bus.key_valid = 1'b0;
        bus.key_code  = 4'h0;
    endtask

    // '=' then adder answers on the second CALC cycle; sum checked in SHOW.
    task automatic do_calc(input logic [W-1:0] ea, input logic [W-1:0] eb);
        int n;
        sb_q.push_back(bcd_add(ea, eb));
        press(KeyEqual);
        check_val("start_pulse", W'(bus.add_start), W'(1));
        check_val("busy_calc", W'(bus.busy), W'(1));
        check_val("calc_disp_opb", bus.disp_value, eb);
        tick();
        check_val("start_single", W'(bus.add_start), W'(0));
        bus.sum_in   = bcd_add(bus.op_a, bus.op_b);
        bus.add_done = 1'b1;
        n = 0;
        tick();
        while (bus.busy && n < 8) begin
            tick();
            n++;
        end
        bus.add_done = 1'b0;
        check_val("show_reached", W'(bus.busy), W'(0));
        check_val("show_latency", W'(n), W'(0));
        if (sb_q.size() != 0) check_val("sum_disp", bus.disp_value, sb_q.pop_front());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.key_code  = 4'h0;
        bus.key_valid = 1'b0;
        bus.add_done  = 1'b0;
        bus.sum_in    = '0;

        // Reset values
        tick();
        tick();
        check_val("rst_op_a", bus.op_a, '0);
        check_val("rst_op_b", bus.op_b, '0);
        check_val("rst_disp", bus.disp_value, '0);
        check_val("rst_busy", W'(bus.busy), W'(0));
        check_val("rst_err", W'(bus.err), W'(0));
        check_val("rst_start", W'(bus.add_start), W'(0));
        rst_n = 1'b1;
        tick();

        // 123 + 456 = 579
        press(4'd1);
        press(4'd2);
        press(4'd3);
        check_val("op_a_123", bus.op_a, 12'h123);
        check_val("disp_a_123", bus.disp_value, 12'h123);
        press(KeyPlus);
        check_val("disp_b_empty", bus.disp_value, 12'h000);
        press(4'd4);
        press(4'd5);
        press(4'd6);
        check_val("op_b_456", bus.op_b, 12'h456);
        check_val("disp_b_456", bus.disp_value, 12'h456);
        do_calc(12'h123, 12'h456);
        check_val("start_count_1", W'(start_cnt), W'(1));

        // Digit from SHOW starts a new A; fourth digit ignored; empty B
        press(4'd9);
        check_val("show_digit_a", bus.op_a, 12'h009);
        check_val("show_digit_b", bus.op_b, 12'h000);
        press(4'd8);
        press(4'd7);
        press(4'd6);
        check_val("op_a_987", bus.op_a, 12'h987);
        press(KeyPlus);
        do_calc(12'h987, 12'h000);

        // Misplaced '=' and '+' ignored
        press(KeyClear);
        check_val("clr_disp", bus.disp_value, 12'h000);
        press(KeyEqual);
        check_val("eq_in_a_busy", W'(bus.busy), W'(0));
        press(4'd1);
        check_val("eq_in_a_op_a", bus.op_a, 12'h001);
        press(KeyPlus);
        press(KeyPlus);
        check_val("plus_in_b_op_a", bus.op_a, 12'h001);
        press(4'd2);
        check_val("plus_in_b_op_b", bus.op_b, 12'h002);
        check_val("start_count_2", W'(start_cnt), W'(2));

        // Timeout: four CALC cycles without add_done
        press(KeyEqual);
        tick();
        tick();
        tick();
        check_val("calc_cycle4_busy", W'(bus.busy), W'(1));
        check_val("calc_cycle4_err", W'(bus.err), W'(0));
        tick();
        check_val("tmo_err", W'(bus.err), W'(1));
        check_val("tmo_busy", W'(bus.busy), W'(0));
        check_val("tmo_disp", bus.disp_value, 12'hFFF);
        press(4'd3);
        check_val("err_digit_ignored", W'(bus.err), W'(1));
        check_val("err_op_a_kept", bus.op_a, 12'h001);
        press(KeyClear);
        check_val("err_clr_err", W'(bus.err), W'(0));
        check_val("err_clr_disp", bus.disp_value, 12'h000);

        // Clear together with add_done
        press(4'd7);
        press(KeyPlus);
        press(4'd8);
        press(KeyEqual);
        tick();
        bus.sum_in    = 12'h015;
        bus.add_done  = 1'b1;
        bus.key_code  = KeyClear;
        bus.key_valid = 1'b1;
        tick();
        bus.add_done  = 1'b0;
        bus.key_valid = 1'b0;
        check_val("clrdone_busy", W'(bus.busy), W'(0));
        check_val("clrdone_op_a", bus.op_a, 12'h000);
        check_val("clrdone_op_b", bus.op_b, 12'h000);
        tick();
        check_val("clrdone_disp", bus.disp_value, 12'h000);

        // Clear on the timeout edge
        press(KeyPlus);
        press(KeyEqual);
        tick();
        tick();
        tick();
        press(KeyClear);
        check_val("clrtmo_err", W'(bus.err), W'(0));
        check_val("clrtmo_busy", W'(bus.busy), W'(0));
        check_val("clrtmo_disp", bus.disp_value, 12'h000);

        // Asynchronous reset mid-CALC
        press(4'd1);
        press(KeyPlus);
        press(4'd2);
        press(KeyEqual);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("arst_start", W'(bus.add_start), W'(0));
        check_val("arst_busy", W'(bus.busy), W'(0));
        check_val("arst_op_a", bus.op_a, 12'h000);
        check_val("arst_disp", bus.disp_value, 12'h000);
        tick();
        tick();
        rst_n = 1'b1;
        press(4'd5);
        check_val("arst_after_op_a", bus.op_a, 12'h005);

        check_val("start_total", W'(start_cnt), W'(5));
        check_val("start_never_double", W'(start_double), W'(0));
        check_val("sb_drained", W'(sb_q.size()), W'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
